// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   state_e    : arbiter FSM states
//   ABORT_DATA : read data returned when a memory transaction times out
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared single-port memory.
// Only one memory transaction is outstanding at a time.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_valid) and address
//   if_rdata/if_valid     : fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request, write enable, address, store data
//   dm_rdata/dm_valid     : load data and one-cycle completion pulse
//   stall_if/stall_mem    : request pending and not yet completing this cycle
//   mem_req/mem_we/mem_addr/mem_wdata : request to the shared memory
//   mem_ack/mem_rdata     : memory completion, read data valid with the ack
//   mem_err               : sticky timeout flag
//   dbg_state/dbg_starve_cnt/dbg_tmo_cnt : internal state exposed for observation
//
// Handshake: a port raises *_req with stable address/data and keeps it high
// until its *_valid pulse; the pulse lasts exactly one cycle and comes at the
// earliest two cycles after the grant cycle. The memory sees mem_req high for
// the whole BUSY phase and answers with a single-cycle mem_ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned SW         = $clog2(STARVE_MAX + 1),
  parameter int unsigned TW         = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          mem_err,
  output state_e        dbg_state,
  output logic [SW-1:0] dbg_starve_cnt,
  output logic [TW-1:0] dbg_tmo_cnt
);

  state_e        state_q,    state_d;
  logic          gnt_d_q,    gnt_d_d;     // 1: current transaction belongs to the data port
  logic          we_q,       we_d;
  logic [31:0]   addr_q,     addr_d;
  logic [31:0]   wdata_q,    wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          err_q,      err_d;
  logic [SW-1:0] starve_q,   starve_d;
  logic [TW-1:0] tmo_q,      tmo_d;

  logic          starved;

  // The fetch port has waited through STARVE_MAX data grants.
  assign starved = (starve_q == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
      starve_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d_d    = gnt_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      IDLE: begin
        // Data port has priority unless the fetch port is starved.
        if (dm_req && !(if_req && starved)) begin
          state_d = BUSY_D;
          gnt_d_d = 1'b1;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          tmo_d   = '0;
          if (if_req && !starved) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_req) begin
          state_d  = BUSY_I;
          gnt_d_d  = 1'b0;
          we_d     = 1'b0;
          addr_d   = if_addr;
          tmo_d    = '0;
          starve_d = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_d = DONE;
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_d   = TW'(TIMEOUT);
          err_d   = 1'b1;
          if (state_q == BUSY_I) begin
            if_rdata_d = ABORT_DATA;
          end else begin
            dm_rdata_d = ABORT_DATA;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_we    = (state_q == BUSY_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

  assign if_valid  = (state_q == DONE) && !gnt_d_q;
  assign dm_valid  = (state_q == DONE) &&  gnt_d_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;
  assign dbg_tmo_cnt    = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  state_e      dbg_state;
  logic [2:0]  dbg_starve_cnt;
  logic [3:0]  dbg_tmo_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_valid       (if_valid),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_valid       (dm_valid),
    .stall_if       (stall_if),
    .stall_mem      (stall_mem),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt),
    .dbg_tmo_cnt    (dbg_tmo_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];   // expected grant order, 1 = data port

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rd;
    int          ack_lat;   // BUSY cycle carrying mem_ack, 0 = never
    int          exp_lat;   // cycles from request cycle to valid
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with the arbiter in IDLE.
  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    bit seen;
    if (v.is_d) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({name, "_mem_req"},  32'(mem_req),  32'd1);
        chk({name, "_mem_addr"}, mem_addr,      v.addr);
        chk({name, "_mem_we"},   32'(mem_we),   32'(v.we));
        if (v.is_d && v.we) chk({name, "_mem_wdata"}, mem_wdata, v.wdata);
      end
      if (if_valid || dm_valid) begin
        seen = 1'b1;
        chk({name, "_latency"},  32'(cyc),      32'(v.exp_lat));
        chk({name, "_dm_valid"}, 32'(dm_valid), 32'(v.is_d));
        chk({name, "_if_valid"}, 32'(if_valid), 32'(!v.is_d));
        chk({name, "_if_rdata"}, if_rdata,      v.exp_if);
        chk({name, "_dm_rdata"}, dm_rdata,      v.exp_dm);
        chk({name, "_mem_err"},  32'(mem_err),  32'(v.exp_err));
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_ack = 1'b0;
      end else begin
        mem_ack   = (v.ack_lat != 0) && (cyc == v.ack_lat);
        mem_rdata = v.mem_rd;
      end
    end
    if (!seen) begin
      chk({name, "_valid_timeout"}, 32'd0, 32'd1);
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    end
    @(negedge clk);
    chk({name, "_idle_state"},  32'(dbg_state), 32'(IDLE));
    chk({name, "_valid_once"},  32'(if_valid | dm_valid), 32'd0);
    chk({name, "_idle_mem_req"}, 32'(mem_req), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [0:0] got;
    logic [0:0] exp_g;
    state_e     prev_st;
    int         d_grants;
    bit         done;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,  32'h8C010004, 1,  2,  32'h8C010004, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h20, 32'h0,  32'h12345678, 3,  4,  32'h8C010004, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h40, 32'h55, 32'hFFFFFFFF, 2,  3,  32'h8C010004, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h14, 32'h0,  32'hCAFEF00D, 5,  6,  32'hCAFEF00D, 32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h44, 32'h0,  32'hA5A5A5A5, 14, 15, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h48, 32'h0,  32'h0BADF00D, 15, 16, 32'hCAFEF00D, 32'h0BADF00D, 1'b0};

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state, observed before any clock edge.
    #3;
    chk("rst_state",    32'(dbg_state), 32'(IDLE));
    chk("rst_mem_req",  32'(mem_req),   32'd0);
    chk("rst_valids",   32'({if_valid, dm_valid}), 32'd0);
    chk("rst_mem_err",  32'(mem_err),   32'd0);
    chk("rst_mem_addr", mem_addr,       32'd0);
    chk("rst_if_rdata", if_rdata,       32'd0);
    chk("rst_starve",   32'(dbg_starve_cnt), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-port transactions from the table.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests: data wins, then fetch.
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h55;
    @(negedge clk);
    chk("sim_state_d",  32'(dbg_state), 32'(BUSY_D));
    chk("sim_mem_we",   32'(mem_we),    32'd1);
    chk("sim_mem_addr", mem_addr,       32'h40);
    chk("sim_wdata",    mem_wdata,      32'h55);
    chk("sim_starve1",  32'(dbg_starve_cnt), 32'd1);
    chk("sim_stalls",   32'({stall_if, stall_mem}), 32'b11);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("sim_dm_valid", 32'({if_valid, dm_valid}), 32'b01);
    chk("sim_stall_mem", 32'(stall_mem), 32'd0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("sim_gap_idle", 32'(dbg_state), 32'(IDLE));
    chk("sim_gap_valid", 32'({if_valid, dm_valid}), 32'b00);
    @(negedge clk);
    chk("sim_state_i",   32'(dbg_state), 32'(BUSY_I));
    chk("sim_i_addr",    mem_addr,       32'h30);
    chk("sim_i_we",      32'(mem_we),    32'd0);
    chk("sim_starve0",   32'(dbg_starve_cnt), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    @(negedge clk);
    chk("sim_if_valid",  32'({if_valid, dm_valid}), 32'b10);
    chk("sim_if_rdata",  if_rdata, 32'h11112222);
    chk("sim_dm_keep",   dm_rdata, 32'h0BADF00D);
    if_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("sim_end_valid", 32'({if_valid, dm_valid}), 32'b00);

    // Starvation: back-to-back loads against a waiting fetch.
    exp_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h50;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    mem_rdata = 32'h00005EED;
    prev_st  = dbg_state;
    d_grants = 0;
    done     = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (prev_st == IDLE && (dbg_state == BUSY_D || dbg_state == BUSY_I)) begin
        got = (dbg_state == BUSY_D);
        if (exp_q.size() == 0) begin
          chk("starve_extra_grant", 32'(got), 32'd2);
        end else begin
          exp_g = exp_q.pop_front();
          chk("starve_grant_order", 32'(got), 32'(exp_g));
        end
        if (got) begin
          d_grants++;
          chk("starve_cnt_inc", 32'(dbg_starve_cnt), 32'(d_grants));
        end else begin
          chk("starve_cnt_clr", 32'(dbg_starve_cnt), 32'd0);
          chk("starve_i_addr",  mem_addr, 32'h50);
        end
      end
      if (dm_valid) dm_addr = dm_addr + 32'd4;
      if (if_valid) begin
        done = 1'b1;
        if_req = 1'b0; dm_req = 1'b0;
      end
      mem_ack = mem_req;
      prev_st = dbg_state;
    end
    chk("starve_done",      32'(done), 32'd1);
    chk("starve_q_empty",   32'(exp_q.size()), 32'd0);
    chk("starve_d_grants",  32'(d_grants), 32'd4);
    mem_ack = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Timeout: no ack ever, sticky error afterwards.
    run_vec('{1'b1, 1'b0, 32'h60, 32'h0, 32'h0, 0, 16, 32'h00005EED, 32'hDEADBEEF, 1'b1}, "tmo");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tmo_err_sticky", 32'(mem_err), 32'd1);
    end

    // Reset in the middle of a data transaction.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h70;
    @(negedge clk);
    chk("rstmid_busy", 32'(dbg_state), 32'(BUSY_D));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(mem_req),   32'd0);
    chk("rstmid_state",   32'(dbg_state), 32'(IDLE));
    chk("rstmid_err",     32'(mem_err),   32'd0);
    chk("rstmid_dm_rdata", dm_rdata,      32'd0);
    dm_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstmid_no_valid", 32'({if_valid, dm_valid}), 32'b00);
    end
    rst_n = 1'b1;
    run_vec('{1'b0, 1'b0, 32'h80, 32'h0, 32'h600D600D, 1, 2, 32'h600D600D, 32'h0, 1'b0}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data-port grants allowed while a fetch request waits.
REQ-002 Parameter TIMEOUT, default 15: BUSY cycles without mem_ack before a transaction is aborted.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 if_req  input  1  fetch request; held high until if_valid.
REQ-006 if_addr  input  32  fetch address; stable while if_req is high.
REQ-007 if_rdata  output  32  fetched word.
REQ-008 if_valid  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req  input  1  data request; held high until dm_valid.
REQ-010 dm_we  input  1  data write enable, qualified by dm_req.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_rdata  output  32  load data.
REQ-014 dm_valid  output  1  one-cycle data completion pulse.
REQ-015 stall_if  output  1  if_req & ~if_valid, combinational.
REQ-016 stall_mem  output  1  dm_req & ~dm_valid, combinational.
REQ-017 mem_req  output  1  request to the shared single-port memory.
REQ-018 mem_we  output  1  write enable to memory.
REQ-019 mem_addr  output  32  registered memory address.
REQ-020 mem_wdata  output  32  registered memory write data.
REQ-021 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-022 mem_rdata  input  32  memory read data.
REQ-023 mem_err  output  1  sticky timeout flag.

Function
REQ-024 FSM states are IDLE, BUSY_I, BUSY_D and DONE; exactly one transaction is outstanding at a time.
REQ-025 In IDLE with only one request pending, that port is granted: address, write enable and write data are latched, and the next state is BUSY_I or BUSY_D.
REQ-026 In IDLE with both requests pending, the data port wins unless starve_cnt == STARVE_MAX, in which case the fetch port wins.
REQ-027 starve_cnt (width clog2(STARVE_MAX+1)) increments on each D grant made while if_req is high, clears on every I grant, and saturates at STARVE_MAX.
REQ-028 mem_req is high only in BUSY_I and BUSY_D; mem_we equals the latched dm_we in BUSY_D and is 0 in BUSY_I.
REQ-029 On mem_ack in a BUSY state, mem_rdata is captured into if_rdata (BUSY_I) or into dm_rdata (BUSY_D read), and the next state is DONE.
REQ-030 A data write leaves dm_rdata unchanged.
REQ-031 In DONE, the matching valid output is high for exactly one cycle, mem_req is 0, and the next state is IDLE; no grant is made in DONE.
REQ-032 Minimum latency is 2 cycles from the request cycle to valid (request in IDLE at cycle 0, mem_ack in cycle 1, valid in cycle 2); the minimum issue interval is 3 cycles.
REQ-033 tmo_cnt clears on entry to a BUSY state and increments each BUSY cycle without mem_ack.
REQ-034 When tmo_cnt reaches TIMEOUT, the transaction aborts: the next state is DONE, the read data output for the port is 32'hDEADBEEF, and mem_err is set.
REQ-035 mem_err stays set until reset.
REQ-036 When mem_ack and the timeout coincide, mem_ack wins: normal completion, and mem_err is not set.
REQ-037 A request that drops before its grant is ignored; a request that drops after its grant still completes, and its valid pulse is emitted.

Reset
REQ-038 While rst_n is low, all of the following are held immediately, without waiting for clk: state IDLE, mem_req/mem_we/if_valid/dm_valid/mem_err 0, if_rdata/dm_rdata/mem_addr/mem_wdata 0, starve_cnt and tmo_cnt 0.
REQ-039 A reset mid-transaction abandons it with no valid pulse; the first grant is possible in the first clk edge after rst_n rises.

Structure
REQ-040 Package mem_arb_pkg holds the state enum and the constant ABORT_DATA = 32'hDEADBEEF.
REQ-041 The block is a single module with no sub-modules; the counters and FSM are local.

Verification
REQ-042 Fetch only: if_req, if_addr=0x10, mem_ack in the first BUSY cycle with mem_rdata=0x8C010004 -> if_valid in cycle 2, if_rdata=0x8C010004, mem_addr=0x10.
REQ-043 Simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0x55 -> D granted first with mem_we=1 and mem_wdata=0x55; I granted in the next IDLE; both valids pulse once.
REQ-044 Starvation: dm_req held high with back-to-back new loads plus if_req held high -> exactly 4 D grants, then an I grant, then starve_cnt=0.
REQ-045 Timeout: mem_ack never asserted -> after 15 BUSY cycles dm_valid=1, dm_rdata=0xDEADBEEF, mem_err=1, and it stays 1.
REQ-046 Reset during BUSY_D -> mem_req=0 immediately, no dm_valid, state IDLE, and a subsequent fetch completes normally.
